// File: rtl/uart_pkg.sv
// Shared types for the UART transmit scheduler: FSM states, UART register map, bus request struct.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POLL,
    S_CHECK,
    S_WRITE,
    S_GAP
  } state_e;

  localparam logic [31:0] UART_CTRL_ADDR  = 32'h8000_0000;
  localparam logic [31:0] UART_TRANS_ADDR = 32'h8000_0008;

  typedef struct packed {
    logic        read;
    logic        write;
    logic [31:0] addr;
    logic [3:0]  size;
    logic [31:0] din;
  } uart_bus_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first asserted request at or after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          vld
);

  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!vld && req[j]) begin
        vld    = 1'b1;
        gnt[j] = 1'b1;
        idx    = j[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one memory-mapped UART transmitter between NUM_REQ byte streams (poll, write, gap).
// Optional UART_TX_SCHED_LOCK_EN: hold arbitration on one requester until its last byte.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter  int          NUM_REQ    = 2,
  parameter  logic [31:0] UART_CTRL  = UART_CTRL_ADDR,
  parameter  logic [31:0] UART_TRANS = UART_TRANS_ADDR,
  parameter  int          GAP_CYCLES = 2,
  localparam int          IW         = $clog2(NUM_REQ),
  localparam int          GW         = $clog2(GAP_CYCLES + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  input  logic [NUM_REQ-1:0][7:0] req_data_i,
  input  logic [NUM_REQ-1:0]      req_last_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  output logic [31:0]             uart_addr_o,
  output logic                    uart_write_o,
  output logic                    uart_read_o,
  output logic [3:0]              uart_size_o,
  output logic [31:0]             uart_din_o,
  input  logic [31:0]             uart_dout_i,
  output logic                    busy_o,
  output logic [IW-1:0]           grant_o
);

  state_e               state_q, state_d;
  logic [IW-1:0]        ptr_q, grant_q, arb_idx, ptr_next;
  logic [7:0]           byte_q;
  logic [GW-1:0]        gap_q;
  logic [NUM_REQ-1:0]   elig, arb_gnt;
  logic                 arb_vld, take;
  uart_bus_t            bus;
  logic                 unused_dout;

  assign unused_dout = ^uart_dout_i[31:1];

`ifdef UART_TX_SCHED_LOCK_EN
  logic locked_q;
  assign elig = locked_q ? (req_valid_i & (NUM_REQ'(1) << grant_q)) : req_valid_i;
`else
  logic unused_last;
  assign unused_last = ^req_last_i;
  assign elig        = req_valid_i;
`endif

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req (elig),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .vld (arb_vld)
  );

  // Gated by rst_ni so no accept pulse can leak out while reset is held.
  assign take        = (state_q == S_IDLE) && arb_vld && rst_ni;
  assign req_ready_o = take ? arb_gnt : '0;
  assign ptr_next    = (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      grant_q  <= '0;
      byte_q   <= '0;
      gap_q    <= '0;
`ifdef UART_TX_SCHED_LOCK_EN
      locked_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gap_q   <= (state_q == S_GAP) ? gap_q + 1'b1 : '0;
      if (take) begin
        byte_q  <= req_data_i[arb_idx];
        grant_q <= arb_idx;
`ifdef UART_TX_SCHED_LOCK_EN
        // Pointer only moves once the packet closes; until then the owner stays locked in.
        if (req_last_i[arb_idx]) begin
          ptr_q    <= ptr_next;
          locked_q <= 1'b0;
        end else begin
          locked_q <= 1'b1;
        end
`else
        ptr_q   <= ptr_next;
`endif
      end
    end
  end

  always_comb begin
    state_d = state_q;
    bus     = '0;
    case (state_q)
      S_IDLE:  if (arb_vld) state_d = S_POLL;
      S_POLL: begin
        bus.read = 1'b1;
        bus.addr = UART_CTRL;
        bus.size = 4'b1111;
        state_d  = S_CHECK;
      end
      S_CHECK: state_d = uart_dout_i[0] ? S_WRITE : S_POLL;
      S_WRITE: begin
        bus.write = 1'b1;
        bus.addr  = UART_TRANS;
        bus.size  = 4'b0001;
        bus.din   = {24'b0, byte_q};
        state_d   = S_GAP;
      end
      S_GAP:   if (gap_q == GW'(GAP_CYCLES - 1)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign uart_read_o  = bus.read;
  assign uart_write_o = bus.write;
  assign uart_addr_o  = bus.addr;
  assign uart_size_o  = bus.size;
  assign uart_din_o   = bus.din;
  assign busy_o       = (state_q != S_IDLE);
  assign grant_o      = grant_q;

endmodule
